// File: rtl/palram_ctrl_if.sv
// Client-side request/ack bundle for the palette SRAM controller (video fetch + CPU access).
`timescale 1ns/1ps
interface palram_ctrl_if;
  // Handshake: a client raises req (level) with stable addr/we/wdata and holds it until its
  // one-cycle ack pulse; it must drop req in the ack cycle, otherwise a new access is started.
  logic        vid_req;
  logic [12:0] vid_addr;
  logic        vid_ack;
  logic [7:0]  vid_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  vid_ack, vid_data, cpu_ack, cpu_rdata
  );

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output vid_ack, vid_data, cpu_ack, cpu_rdata
  );
endinterface

// File: rtl/palram_ctrl.sv
// Palette SRAM initiator: arbitrates video/CPU requests and sequences nCE/nOE/nWE strobes
// for an 8Kx8 asynchronous RAM with a shared bidirectional data bus.
`timescale 1ns/1ps
module palram_ctrl #(
  parameter int ACCESS_CYCLES = 3,
  parameter int WE_CYCLES     = 2
) (
  input  logic        clk_24m,
  input  logic        nreset,
  palram_ctrl_if.slave bus,
  output logic [12:0] pal_addr,
  inout  wire  [7:0]  pal_data,
  output logic        npal_ce,
  output logic        npal_oe,
  output logic        npal_we,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    RECOVER  = 3'd2,
    WR_SETUP = 3'd3,
    WR_PULSE = 3'd4,
    WR_HOLD  = 3'd5
  } state_t;

  localparam logic [3:0] ACC_LOAD = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] WE_LOAD  = 4'(WE_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        last_vid;
  logic        owner_vid;
  logic        drive;
  logic [7:0]  wdata_q;
  logic        grant_vid;

  // Video wins a tie unless it also won the previous grant, so the CPU waits at most one video access.
  assign grant_vid = bus.vid_req && (!bus.cpu_req || !last_vid);

  assign pal_data  = drive ? wdata_q : 8'hzz;
  assign state_dbg = state;

  always_ff @(posedge clk_24m or negedge nreset) begin
    if (!nreset) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      last_vid      <= 1'b0;
      owner_vid     <= 1'b0;
      drive         <= 1'b0;
      wdata_q       <= 8'h00;
      pal_addr      <= 13'h0000;
      npal_ce       <= 1'b1;
      npal_oe       <= 1'b1;
      npal_we       <= 1'b1;
      bus.vid_ack   <= 1'b0;
      bus.vid_data  <= 8'h00;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_rdata <= 8'h00;
    end else begin
      bus.vid_ack <= 1'b0;
      bus.cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vid) begin
            owner_vid <= 1'b1;
            last_vid  <= 1'b1;
            pal_addr  <= bus.vid_addr;
            npal_ce   <= 1'b0;
            npal_oe   <= 1'b0;
            cnt       <= ACC_LOAD;
            state     <= RD;
          end else if (bus.cpu_req) begin
            owner_vid <= 1'b0;
            last_vid  <= 1'b0;
            pal_addr  <= bus.cpu_addr;
            wdata_q   <= bus.cpu_wdata;
            npal_ce   <= 1'b0;
            if (bus.cpu_we) begin
              drive <= 1'b1;
              state <= WR_SETUP;
            end else begin
              npal_oe <= 1'b0;
              cnt     <= ACC_LOAD;
              state   <= RD;
            end
          end
        end
        RD: begin
          if (cnt == 4'd0) begin
            npal_ce <= 1'b1;
            npal_oe <= 1'b1;
            state   <= RECOVER;
            if (owner_vid) begin
              bus.vid_data <= pal_data;
              bus.vid_ack  <= 1'b1;
            end else begin
              bus.cpu_rdata <= pal_data;
              bus.cpu_ack   <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RECOVER: state <= IDLE;
        WR_SETUP: begin
          npal_we <= 1'b0;
          cnt     <= WE_LOAD;
          state   <= WR_PULSE;
        end
        WR_PULSE: begin
          if (cnt == 4'd0) begin
            npal_ce     <= 1'b1;
            npal_we     <= 1'b1;
            bus.cpu_ack <= 1'b1;
            state       <= WR_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WR_HOLD: begin
          // Data stays on the bus through this cycle to cover the RAM's hold time after nWE rises.
          drive <= 1'b0;
          state <= IDLE;
        end
        default: begin
          npal_ce <= 1'b1;
          npal_oe <= 1'b1;
          npal_we <= 1'b1;
          drive   <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_palram_ctrl.sv
// Directed bench for palram_ctrl: SRAM model on the pins, strobe-width/latency measurement, arbitration order.
`timescale 1ns/1ps
module tb_palram_ctrl;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #21 clk = ~clk;

  // Default-parameter instance with an SRAM model
  palram_ctrl_if bus ();
  wire  [7:0]  pal_data;
  logic [12:0] pal_addr;
  logic        npal_ce, npal_oe, npal_we;
  logic [2:0]  state_dbg;

  palram_ctrl u_dut (
    .clk_24m(clk), .nreset(nreset), .bus(bus),
    .pal_addr(pal_addr), .pal_data(pal_data),
    .npal_ce(npal_ce), .npal_oe(npal_oe), .npal_we(npal_we),
    .state_dbg(state_dbg)
  );

  // Narrow/wide strobe instance; its RAM returns a constant
  palram_ctrl_if bus2 ();
  wire  [7:0]  pal_data2;
  logic [12:0] pal_addr2;
  logic        npal_ce2, npal_oe2, npal_we2;
  logic [2:0]  state_dbg2;

  palram_ctrl #(.ACCESS_CYCLES(1), .WE_CYCLES(15)) u_dut2 (
    .clk_24m(clk), .nreset(nreset), .bus(bus2),
    .pal_addr(pal_addr2), .pal_data(pal_data2),
    .npal_ce(npal_ce2), .npal_oe(npal_oe2), .npal_we(npal_we2),
    .state_dbg(state_dbg2)
  );

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (pal_data[g]);
    pullup (pal_data2[g]);
  end

  logic [7:0]  mem [0:8191];
  logic        bd_we = 1'b0;
  logic [12:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;

  assign pal_data  = (!npal_ce && !npal_oe) ? mem[pal_addr] : 8'hzz;
  assign pal_data2 = (!npal_ce2 && !npal_oe2) ? 8'h77 : 8'hzz;

  // Backdoor preload on rising edges, RAM writes sampled on falling edges
  always @(clk) begin
    if (clk && bd_we) mem[bd_addr] = bd_data;
    else if (!clk && !npal_ce && !npal_we) mem[pal_addr] = pal_data;
  end

  int total = 0;
  int bad = 0;
  int lat, rd_w, we_w, drv_first, drv_last, we_first, we_last, ack_n, oe_wr, data_bad, other_ack;
  logic [7:0] rdata;
  logic [0:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [12:0] a, input logic [7:0] d);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    @(posedge clk); #1 bd_we = 1'b0;
    @(negedge clk);
  endtask

  // One access on the default instance; measures strobe widths relative to the request negedge.
  task automatic run_access(input bit is_vid, input bit we, input logic [12:0] addr, input logic [7:0] wd);
    bit done, ack, oack, drv;
    done = 0;
    lat = 0; rd_w = 0; we_w = 0; ack_n = 0; oe_wr = 0; data_bad = 0; other_ack = 0;
    drv_first = -1; drv_last = -1; we_first = -1; we_last = -1; rdata = 8'h00;
    if (is_vid) begin
      bus.vid_addr = addr; bus.vid_req = 1'b1;
    end else begin
      bus.cpu_addr = addr; bus.cpu_we = we; bus.cpu_wdata = wd; bus.cpu_req = 1'b1;
    end
    for (int c = 1; c <= 30 && !done; c++) begin
      @(negedge clk);
      drv = npal_oe && (pal_data !== 8'hFF);
      if (!npal_ce && !npal_oe) rd_w++;
      if (!npal_we) begin
        we_w++;
        if (we_first < 0) we_first = c;
        we_last = c;
      end
      if (drv) begin
        if (drv_first < 0) drv_first = c;
        drv_last = c;
        if (pal_data !== wd) data_bad++;
      end
      if (!npal_oe && (state_dbg >= 3'd3)) oe_wr++;
      ack  = is_vid ? bus.vid_ack : bus.cpu_ack;
      oack = is_vid ? bus.cpu_ack : bus.vid_ack;
      if (oack) other_ack++;
      if (ack) begin
        ack_n++;
        if (lat == 0) begin
          lat = c;
          rdata = is_vid ? bus.vid_data : bus.cpu_rdata;
        end
        bus.vid_req = 1'b0;
        bus.cpu_req = 1'b0;
      end else if (lat != 0) begin
        done = 1;
      end
    end
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b0;
    chk("access_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_access2(input bit is_vid, input bit we);
    bit done, ack;
    done = 0; lat = 0; rd_w = 0; we_w = 0; rdata = 8'h00;
    if (is_vid) begin
      bus2.vid_addr = 13'h0123; bus2.vid_req = 1'b1;
    end else begin
      bus2.cpu_addr = 13'h0456; bus2.cpu_we = we; bus2.cpu_wdata = 8'h3C; bus2.cpu_req = 1'b1;
    end
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      if (!npal_ce2 && !npal_oe2) rd_w++;
      if (!npal_we2) we_w++;
      ack = is_vid ? bus2.vid_ack : bus2.cpu_ack;
      if (ack) begin
        lat = c;
        rdata = is_vid ? bus2.vid_data : bus2.cpu_rdata;
        bus2.vid_req = 1'b0;
        bus2.cpu_req = 1'b0;
        done = 1;
      end
    end
    bus2.vid_req = 1'b0;
    bus2.cpu_req = 1'b0;
    chk("access2_timeout", 32'(done), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int ngr, last_c, cack;
    bit seen;
    logic [0:0] g, e;
    bus.vid_req = 0; bus.vid_addr = '0; bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus2.vid_req = 0; bus2.vid_addr = '0; bus2.cpu_req = 0; bus2.cpu_we = 0; bus2.cpu_addr = '0; bus2.cpu_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_nce", 32'(npal_ce), 32'd1);
    chk("rst_noe", 32'(npal_oe), 32'd1);
    chk("rst_nwe", 32'(npal_we), 32'd1);
    chk("rst_bus_released", 32'(pal_data), 32'hFF);
    chk("rst_addr", 32'(pal_addr), 32'h0);
    chk("rst_acks", {30'd0, bus.vid_ack, bus.cpu_ack}, 32'd0);
    chk("rst_data", {16'd0, bus.vid_data, bus.cpu_rdata}, 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    nreset = 1'b1;
    @(negedge clk);

    // Video read 0x1A2B
    preload(13'h1A2B, 8'h5C);
    run_access(1, 0, 13'h1A2B, 8'h00);
    chk("vrd_latency", 32'(lat), 32'd4);
    chk("vrd_strobe_width", 32'(rd_w), 32'd3);
    chk("vrd_data", 32'(rdata), 32'h5C);
    chk("vrd_ack_count", 32'(ack_n), 32'd1);
    chk("vrd_no_drive", 32'(drv_first), 32'hFFFF_FFFF);
    chk("vrd_no_cpu_ack", 32'(other_ack), 32'd0);

    // CPU write 0x0FFF <= 0xA5
    run_access(0, 1, 13'h0FFF, 8'hA5);
    chk("wr_we_width", 32'(we_w), 32'd2);
    chk("wr_setup", 32'(we_first - drv_first), 32'd1);
    chk("wr_hold", 32'(drv_last - we_last), 32'd1);
    chk("wr_latency", 32'(lat), 32'd4);
    chk("wr_ack_count", 32'(ack_n), 32'd1);
    chk("wr_ram", 32'(mem[13'h0FFF]), 32'hA5);
    chk("wr_oe_in_write", 32'(oe_wr), 32'd0);
    chk("wr_bus_value", 32'(data_bad), 32'd0);
    chk("wr_no_read_strobe", 32'(rd_w), 32'd0);

    // Write then read back
    run_access(0, 1, 13'h0010, 8'h3C);
    chk("wr10_oe_in_write", 32'(oe_wr), 32'd0);
    run_access(0, 0, 13'h0010, 8'h00);
    chk("rd10_data", 32'(rdata), 32'h3C);
    chk("rd10_strobe_width", 32'(rd_w), 32'd3);
    chk("rd10_latency", 32'(lat), 32'd4);
    chk("rd10_no_vid_ack", 32'(other_ack), 32'd0);

    // Address boundaries
    run_access(0, 1, 13'h0000, 8'h5A);
    run_access(0, 1, 13'h1FFF, 8'h81);
    chk("b0_ram", 32'(mem[13'h0000]), 32'h5A);
    chk("b1_ram", 32'(mem[13'h1FFF]), 32'h81);
    run_access(1, 0, 13'h1FFF, 8'h00);
    chk("b1_vid_read", 32'(rdata), 32'h81);
    run_access(0, 0, 13'h0000, 8'h00);
    chk("b0_cpu_read", 32'(rdata), 32'h5A);

    // Both held: last grant was CPU, so video first, then strict alternation every 5 clocks
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    bus.vid_addr = 13'h1A2B; bus.vid_req = 1'b1;
    bus.cpu_addr = 13'h0010; bus.cpu_we = 1'b0; bus.cpu_req = 1'b1;
    ngr = 0; last_c = 0;
    for (int c = 1; c <= 60 && ngr < 4; c++) begin
      @(negedge clk);
      if (bus.vid_ack || bus.cpu_ack) begin
        chk("arb_single_ack", 32'(bus.vid_ack && bus.cpu_ack), 32'd0);
        g = bus.cpu_ack;
        e = exp_q.pop_front();
        chk("arb_grant_order", 32'(g), 32'(e));
        chk("arb_data", 32'(g ? bus.cpu_rdata : bus.vid_data), g ? 32'h3C : 32'h5C);
        chk("arb_spacing", 32'(c - last_c), (ngr == 0) ? 32'd4 : 32'd5);
        last_c = c;
        ngr++;
        if (ngr == 4) begin
          bus.vid_req = 1'b0;
          bus.cpu_req = 1'b0;
        end
      end
    end
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b0;
    chk("arb_grant_count", 32'(ngr), 32'd4);
    repeat (3) @(negedge clk);

    // ACCESS_CYCLES=1, WE_CYCLES=15
    run_access2(0, 1);
    chk("w15_we_width", 32'(we_w), 32'd15);
    chk("w15_latency", 32'(lat), 32'd17);
    run_access2(1, 0);
    chk("a1_strobe_width", 32'(rd_w), 32'd1);
    chk("a1_latency", 32'(lat), 32'd2);
    chk("a1_data", 32'(rdata), 32'h77);

    // Reset in the middle of a write pulse
    bus.cpu_addr = 13'h0800; bus.cpu_we = 1'b1; bus.cpu_wdata = 8'h42; bus.cpu_req = 1'b1;
    seen = 0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(negedge clk);
      if (!npal_we) seen = 1;
    end
    chk("mid_wr_pulse_reached", 32'(seen), 32'd1);
    #5 nreset = 1'b0;
    bus.cpu_req = 1'b0;
    #1;
    chk("mid_rst_nwe", 32'(npal_we), 32'd1);
    chk("mid_rst_nce", 32'(npal_ce), 32'd1);
    chk("mid_rst_bus", 32'(pal_data), 32'hFF);
    chk("mid_rst_state", 32'(state_dbg), 32'd0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    cack = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.cpu_ack) cack++;
    end
    chk("mid_rst_no_ack", 32'(cack), 32'd0);
    chk("mid_rst_idle", 32'(state_dbg), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
